// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF input synchronizer, mid-bit sampling at a fixed
// CLKS_PER_BIT ratio, one-cycle done / frame_err strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in,
    output logic [7:0] data_out,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1;
    logic          rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_n;
    logic          done_n, ferr_n, busy_n;
    // Set after a low stop bit: wait for the line to go high before IDLE.
    logic          hold, hold_n;
    logic          sample;

    // Bring the asynchronous line into the clock domain (idle-high reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= in;
            rx_s  <= sync1;
        end
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            hold      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= shreg_n;
            data_out  <= data_n;
            done      <= done_n;
            frame_err <= ferr_n;
            busy      <= busy_n;
            hold      <= hold_n;
        end
    end

    // Next-state logic: half-bit wait in START centres all later samples.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        data_n  = data_out;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        busy_n  = busy;
        hold_n  = hold;
        sample  = (state == START) ? (cnt == LAST_HALF) : (cnt == LAST_FULL);

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (enable && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (hold) begin
                    if (rx_s) begin
                        state_n = IDLE;
                        hold_n  = 1'b0;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                    end
                end else if (sample) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        done_n  = 1'b1;
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        ferr_n = 1'b1;
                        hold_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                hold_n  = 1'b0;
            end
        endcase
    end

endmodule
